// File: rtl/tag_sort_pkg.sv
// Shared encodings and widths for the tag-sort search pipeline.
package tag_sort_pkg;

  localparam int unsigned TAG_W  = 12;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned MASK_W = 16;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_SEARCH = 2'b01,
    OP_INSERT = 2'b10,
    OP_DELETE = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [MASK_W-1:0] nib_onehot(input logic [NIB_W-1:0] nib);
    return MASK_W'(1) << nib;
  endfunction

endpackage

// File: rtl/mask_ge_encoder.sv
// Finds the lowest set bit of a 16-bit node mask at or above a given nibble.
module mask_ge_encoder
  import tag_sort_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  input  logic [NIB_W-1:0]  nibble,
  output logic              found,
  output logic [NIB_W-1:0]  index
);

  logic [MASK_W-1:0] masked;

  always_comb begin
    masked = mask & ~(nib_onehot(nibble) - MASK_W'(1));
    found  = |masked;
    index  = '0;
    // Descending scan so the lowest qualifying bit is the last one written.
    for (int unsigned i = MASK_W; i > 0; i--) begin
      if (masked[i-1]) index = NIB_W'(i - 1);
    end
  end

endmodule

// File: rtl/stage_3_search.sv
// Level-3 bitmap search stage: two-cycle read/modify/write over a node bitmap
// with an INIT sweep that zeroes every node after reset.
module stage_3_search
  import tag_sort_pkg::*;
#(
  parameter int unsigned NODE_AW = 8,
  parameter int unsigned CNT_W   = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               valid_in,
  input  logic [1:0]         op_in,
  input  logic [NODE_AW-1:0] node_addr_in,
  input  logic [TAG_W-1:0]   incoming_tag_in,
  output logic               ready_out,
  output logic               valid_out,
  output logic [1:0]         op_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic [NIB_W-1:0]   result_nibble_out,
  output logic               found_out,
  output logic               backtrack_out,
  output logic               dup_out,
  output logic               node_empty_out,
  output logic [MASK_W-1:0]  mask_out,
  output logic [CNT_W-1:0]   tag_count_out
);

  localparam int unsigned DEPTH = 1 << NODE_AW;

  logic [MASK_W-1:0]  mem [DEPTH];
  state_e             state;
  logic [NODE_AW-1:0] sweep;

  logic               s1_valid;
  op_e                s1_op;
  logic [NODE_AW-1:0] s1_addr;
  logic [TAG_W-1:0]   s1_tag;
  logic [MASK_W-1:0]  s1_mask;

  logic               accept;
  logic               s2_write;
  logic               dup;
  logic [NIB_W-1:0]   nib;
  logic [MASK_W-1:0]  bit_sel;
  logic [MASK_W-1:0]  new_mask;
  logic               enc_found;
  logic [NIB_W-1:0]   enc_index;

  assign accept = valid_in & ena & ready_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_INIT;
      sweep     <= '0;
      ready_out <= 1'b0;
    end else if (state == ST_INIT) begin
      sweep <= sweep + NODE_AW'(1);
      if (sweep == '1) begin
        state     <= ST_RUN;
        ready_out <= 1'b1;
      end
    end
  end

  always_comb begin
    nib      = s1_tag[NIB_W-1:0];
    bit_sel  = nib_onehot(nib);
    new_mask = s1_mask;
    dup      = 1'b0;
    case (s1_op)
      OP_INSERT: begin
        new_mask = s1_mask | bit_sel;
        dup      = |(s1_mask & bit_sel);
      end
      OP_DELETE: begin
        new_mask = s1_mask & ~bit_sel;
        dup      = ~|(s1_mask & bit_sel);
      end
      default: ;
    endcase
    s2_write = ena & s1_valid & ((s1_op == OP_INSERT) | (s1_op == OP_DELETE));
  end

  mask_ge_encoder u_enc (
    .mask   (s1_mask),
    .nibble (nib),
    .found  (enc_found),
    .index  (enc_index)
  );

  // Memory is deliberately outside the async reset; only the sweep clears it.
  // The S2 write is forwarded into S1 so a same-node follow-on never reads stale data.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep] <= '0;
    end else if (s2_write) begin
      mem[s1_addr] <= new_mask;
    end
    if (ena) begin
      s1_mask <= (s2_write && (s1_addr == node_addr_in)) ? new_mask : mem[node_addr_in];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid          <= 1'b0;
      s1_op             <= OP_NOP;
      s1_addr           <= '0;
      s1_tag            <= '0;
      valid_out         <= 1'b0;
      op_out            <= '0;
      tag_out           <= '0;
      result_nibble_out <= '0;
      found_out         <= 1'b0;
      backtrack_out     <= 1'b0;
      dup_out           <= 1'b0;
      node_empty_out    <= 1'b0;
      mask_out          <= '0;
      tag_count_out     <= '0;
    end else if (ena) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op   <= op_e'(op_in);
        s1_addr <= node_addr_in;
        s1_tag  <= incoming_tag_in;
      end
      valid_out <= s1_valid;
      if (s1_valid) begin
        op_out            <= s1_op;
        tag_out           <= s1_tag;
        mask_out          <= new_mask;
        found_out         <= (s1_op == OP_SEARCH) & enc_found;
        backtrack_out     <= (s1_op == OP_SEARCH) & ~enc_found;
        result_nibble_out <= ((s1_op == OP_SEARCH) && enc_found) ? enc_index : '0;
        dup_out           <= dup;
        node_empty_out    <= (s1_op != OP_NOP) && (new_mask == '0);
        if (s1_op == OP_INSERT && !dup && tag_count_out != '1) begin
          tag_count_out <= tag_count_out + CNT_W'(1);
        end else if (s1_op == OP_DELETE && !dup && tag_count_out != '0) begin
          tag_count_out <= tag_count_out - CNT_W'(1);
        end
      end else begin
        op_out            <= '0;
        tag_out           <= '0;
        mask_out          <= '0;
        found_out         <= 1'b0;
        backtrack_out     <= 1'b0;
        result_nibble_out <= '0;
        dup_out           <= 1'b0;
        node_empty_out    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stage_3_search.md
STAGE_3_SEARCH -- requirements
Module: stage_3_search

Interface
REQ-001 The module SHALL have parameter NODE_AW, default 8, giving the level-3 node address width (256 nodes).
REQ-002 The module SHALL have parameter CNT_W, default 13, giving the tag counter width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port ena, input, 1: pipeline advance; same meaning as the stage-3 register enable.
REQ-006 Port valid_in, input, 1: request present on this cycle.
REQ-007 Port op_in, input, 2: request operation; 00 NOP, 01 SEARCH, 10 INSERT, 11 DELETE.
REQ-008 Port node_addr_in, input, NODE_AW: level-3 node index, taken from the forwarded level-1 and level-2 matching tags.
REQ-009 Port incoming_tag_in, input, 12: full tag; bits [3:0] are the level-3 nibble.
REQ-010 Port ready_out, output, 1: high when requests are accepted (RUN state).
REQ-011 Port valid_out, output, 1: result present.
REQ-012 Port op_out, output, 2: echoed operation.
REQ-013 Port tag_out, output, 12: echoed incoming tag.
REQ-014 Port result_nibble_out, output, 4: nibble returned by SEARCH.
REQ-015 Port found_out, output, 1: SEARCH hit.
REQ-016 Port backtrack_out, output, 1: SEARCH miss; the upstream level must retry.
REQ-017 Port dup_out, output, 1: INSERT of a bit already set, or DELETE of a bit already clear.
REQ-018 Port node_empty_out, output, 1: node mask is zero after the operation.
REQ-019 Port mask_out, output, 16: node mask after the operation.
REQ-020 Port tag_count_out, output, CNT_W: number of tags stored.

Function
REQ-021 Storage SHALL be a 2^NODE_AW x 16 bitmap with registered read, where bit i means nibble i is present in that node.
REQ-022 The pipeline SHALL be two stages: S1 reads the memory; S2 computes the result, writes back and registers the outputs.
REQ-023 Latency SHALL be exactly 2 cycles with ena high; with ena low all pipeline registers, memory and counter hold.
REQ-024 A request SHALL be accepted only when valid_in, ena and ready_out are all high; valid_in while ready_out is low is dropped.
REQ-025 SEARCH SHALL return the lowest set index at or above the nibble: found_out=1 and result_nibble_out=index; otherwise found_out=0, backtrack_out=1, result_nibble_out=0.
REQ-026 INSERT SHALL set bit nibble; if the bit was already set, dup_out=1 and the counter is unchanged.
REQ-027 DELETE SHALL clear bit nibble; if the bit was already clear, dup_out=1 and the counter is unchanged.
REQ-028 The counter SHALL increment on a non-dup INSERT and decrement on a non-dup DELETE, saturating at the maximum and at 0.
REQ-029 For back-to-back requests to the same node_addr, S1 SHALL take the S2 write data instead of the memory output, so there is no stale read.
REQ-030 NOP SHALL produce valid_out=1 with no memory write and all flag outputs at 0.
REQ-031 The FSM SHALL have states INIT and RUN.
REQ-032 In INIT, a sweep counter SHALL write zero to all 2^NODE_AW entries, one per cycle independent of ena, with ready_out=0; after the last entry the FSM enters RUN.
REQ-033 RUN SHALL persist until reset.
REQ-034 When an entry's result is not valid, valid_out and all flag outputs SHALL be 0.

Reset
REQ-035 While rst is low, the FSM SHALL be in INIT with the sweep counter at 0.
REQ-036 While rst is low, all outputs SHALL be 0 (ready_out included) and the pipeline valids SHALL be cleared.
REQ-037 Reset asserted mid-operation SHALL discard in-flight requests, and the module SHALL restart the INIT sweep.
REQ-038 Memory contents SHALL be cleared only by the INIT sweep, not by asynchronous reset.

Structure
REQ-039 The tag_sort_pkg package SHALL hold the op encodings, the 12-bit tag width, the 4-bit nibble width and the 16-bit mask width.
REQ-040 The sub-module mask_ge_encoder SHALL be combinational, taking mask[15:0] and nibble[3:0] and producing found and index[3:0]; it is instantiated once in S2.

Verification
REQ-041 Reset release: ready_out stays 0 for 256 cycles, then goes to 1; a SEARCH on any node -> backtrack_out=1, mask_out=0.
REQ-042 INSERT 0x125 then SEARCH 0x123 on node 0x12 -> found_out=1, result_nibble_out=5, tag_count_out=1.
REQ-043 Back-to-back INSERT 0x12A and INSERT 0x12A -> the second returns dup_out=1, mask_out=0x0400, count unchanged.
REQ-044 With node 0x12 holding only 0x125, DELETE 0x125 -> node_empty_out=1, mask_out=0, count=0; DELETE again -> dup_out=1.
REQ-045 With node 0x12 holding only 0x125, SEARCH 0x12F -> backtrack_out=1; holding ena low for 3 cycles mid-flight -> outputs frozen, then the same result follows.
REQ-046 Assert rst while an INSERT is in S1 -> after the new INIT sweep, the node reads 0 and count=0.
